pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
// - Central stall/flush sequencer for the 5-stage RV32I pipeline.
// - Sits beside the decode stage and drives its stall/rollback/flush inputs:
//   stall, stall_1shot, stall_dly, stall_ld, stall_ld_ex, stall_ld_ma, rst_pipe.
// - Detects load-use hazards and converts external memory-busy requests into a global stall.
// - Sequences a multi-cycle pipeline flush after reset or a CPU start command.
// PARAMETERS
// - RST_CYCLES  4   cycles rst_pipe is held per flush sequence; must be >= 1.
// - CNT_W       32  width of the performance counters (STALL_CTRL_PERF_EN only).
// PORTS
// - clk           in   1      core clock
// - rst_n         in   1      asynchronous reset, active-low
// - cpu_start     in   1      pulse: restart the core; triggers a flush sequence
// - stall_req     in   1      memory/fetch busy level; requests a global stall
// - jmp_purge_ex  in   1      a taken jump/branch is purging the ID instruction
// - inst_rs1_id   in   5      rs1 index of the ID instruction
// - inst_rs2_id   in   5      rs2 index of the ID instruction
// - inst_rs1_valid in  1      the ID instruction reads rs1
// - inst_rs2_valid in  1      the ID instruction reads rs2
// - cmd_ld_ex     in   1      a load is in EX
// - rd_adr_ex     in   5      destination register of the EX instruction
// - wbk_rd_reg_ex in   1      the EX instruction writes rd
// - rst_pipe      out  1      synchronous pipeline flush
// - stall         out  1      global stall; freezes all stage registers
// - stall_1shot   out  1      first cycle of a stall episode
// - stall_dly     out  1      stall delayed by one cycle
// - stall_ld      out  1      load-use bubble request for ID (combinational)
// - stall_ld_ex   out  1      stall_ld delayed one non-stalled cycle
// - stall_ld_ma   out  1      stall_ld_ex delayed one non-stalled cycle
// - perf_stall_cnt out CNT_W  stall cycle count (STALL_CTRL_PERF_EN only)
// - perf_ld_cnt   out  CNT_W  load-use bubble count (STALL_CTRL_PERF_EN only)
// BEHAVIOUR
// - FSM states: S_RST, S_RUN, S_STALL.
// - Reset: state=S_RST; cnt=RST_CYCLES-1; rst_pipe=1.
//   stall, stall_dly, stall_ld_ex, stall_ld_ma and the perf counters reset to 0.
// - S_RST: rst_pipe=1 (registered output). cnt decrements each cycle.
//   - cnt==0: go to S_RUN.
//   - cpu_start here: reload cnt=RST_CYCLES-1 (extends the flush).
// - S_RUN, priority order:
//   - cpu_start: go to S_RST, cnt=RST_CYCLES-1.
//   - else stall_req: go to S_STALL.
// - S_STALL: stall=1.
//   - cpu_start: go to S_RST (priority over stall_req).
//   - else ~stall_req: go to S_RUN.
// - stall = (state==S_STALL).
//   - Asserts 1 cycle after stall_req rises; deasserts 1 cycle after it falls.
//   - stall_req is never ignored.
// - stall_dly: register of stall. stall_1shot = stall & ~stall_dly.
// - rst_pipe = (state==S_RST). stall is 0 whenever rst_pipe=1.
// - stall_ld (combinational):
//   - Condition: cmd_ld_ex & wbk_rd_reg_ex & (rd_adr_ex!=0)
//     & ((inst_rs1_valid & inst_rs1_id==rd_adr_ex) | (inst_rs2_valid & inst_rs2_id==rd_adr_ex)).
//   - Gated by: state==S_RUN & ~stall & ~stall_ld_ex & ~jmp_purge_ex.
//   - The ~stall_ld_ex gate limits each hazard to exactly one bubble.
// - stall_ld_ex <= stall_ld and stall_ld_ma <= stall_ld_ex:
//   - Updated only when ~stall.
//   - Both cleared while rst_pipe=1.
// - Simultaneous events:
//   - stall_req in the same cycle as stall_ld: stall_ld is still issued; S_STALL is entered next cycle.
//   - Hazard held during the stall is re-evaluated after release.
// - Reset mid-operation: asserting rst_n clears everything asynchronously; the flush sequence restarts.
// CONFIGURATION
// - STALL_CTRL_PERF_EN defined:
//   - perf_stall_cnt increments on every cycle with stall=1.
//   - perf_ld_cnt increments on every cycle with stall_ld=1.
//   - Both saturate at all-ones and clear on rst_n only (not on rst_pipe).
// - STALL_CTRL_PERF_EN undefined: both outputs are tied to 0 and no counter flops are built.
// TESTING
// - Reset release, RST_CYCLES=4 -> rst_pipe=1 for exactly 4 clks after rst_n rises, then 0; stall=0 throughout.
// - lw x5 in EX, add x6,x5,x1 in ID (rs1 valid) -> stall_ld=1 for 1 clk;
//   stall_ld_ex=1 the next clk; stall_ld_ma=1 the clk after.
// - Same hazard with rd_adr_ex=0, or with jmp_purge_ex=1 -> stall_ld stays 0.
// - stall_req high 3 clks from cycle 10 -> stall=1 in cycles 11-13;
//   stall_1shot=1 at 11 only; stall_dly=1 in 12-14.
// - cpu_start during S_STALL with stall_req held -> rst_pipe=1 and stall=0 next clk;
//   4-clk flush, then S_STALL re-entered.
// - With STALL_CTRL_PERF_EN: 3 stall clks + 2 load-use bubbles -> perf_stall_cnt=3, perf_ld_cnt=2.
//   Counter preset near all-ones saturates and does not wrap.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: global stall, load-use bubbles, reset flush.
// Optional saturating perf counters are built only when STALL_CTRL_PERF_EN is defined.
module pipe_stall_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_start,
  input  logic             stall_req,
  input  logic             jmp_purge_ex,
  input  logic [4:0]       inst_rs1_id,
  input  logic [4:0]       inst_rs2_id,
  input  logic             inst_rs1_valid,
  input  logic             inst_rs2_valid,
  input  logic             cmd_ld_ex,
  input  logic [4:0]       rd_adr_ex,
  input  logic             wbk_rd_reg_ex,
  output logic             rst_pipe,
  output logic             stall,
  output logic             stall_1shot,
  output logic             stall_dly,
  output logic             stall_ld,
  output logic             stall_ld_ex,
  output logic             stall_ld_ma,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_ld_cnt
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      cnt   <= CNT_INIT;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cpu_start always wins: it reloads the flush length from any state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RST: begin
        if (cpu_start) begin
          cnt_nxt = CNT_INIT;
        end else if (cnt == '0) begin
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_RUN: begin
        if (cpu_start) begin
          state_nxt = S_RST;
          cnt_nxt   = CNT_INIT;
        end else if (stall_req) begin
          state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (cpu_start) begin
          state_nxt = S_RST;
          cnt_nxt   = CNT_INIT;
        end else if (!stall_req) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_RST;
        cnt_nxt   = CNT_INIT;
      end
    endcase
  end

  assign rst_pipe    = (state == S_RST);
  assign stall       = (state == S_STALL);
  assign stall_1shot = stall & ~stall_dly;

  assign hazard = cmd_ld_ex & wbk_rd_reg_ex & (rd_adr_ex != 5'd0)
                & ((inst_rs1_valid & (inst_rs1_id == rd_adr_ex))
                 | (inst_rs2_valid & (inst_rs2_id == rd_adr_ex)));

  // Blocking on stall_ld_ex keeps a hazard to a single bubble.
  assign stall_ld = hazard & (state == S_RUN) & ~stall & ~stall_ld_ex & ~jmp_purge_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_dly   <= 1'b0;
      stall_ld_ex <= 1'b0;
      stall_ld_ma <= 1'b0;
    end else begin
      stall_dly <= stall;
      if (rst_pipe) begin
        stall_ld_ex <= 1'b0;
        stall_ld_ma <= 1'b0;
      end else if (!stall) begin
        stall_ld_ex <= stall_ld;
        stall_ld_ma <= stall_ld_ex;
      end
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, ld_cnt_q;

  // Counters survive pipeline flushes; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      ld_cnt_q    <= '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (stall_ld && !(&ld_cnt_q)) ld_cnt_q <= ld_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_ld_cnt    = ld_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_ld_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: flush, load-use bubbles, global stall, restart, perf counters.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cpu_start = 1'b0;
  logic             stall_req = 1'b0;
  logic             jmp_purge_ex = 1'b0;
  logic [4:0]       inst_rs1_id = '0;
  logic [4:0]       inst_rs2_id = '0;
  logic             inst_rs1_valid = 1'b0;
  logic             inst_rs2_valid = 1'b0;
  logic             cmd_ld_ex = 1'b0;
  logic [4:0]       rd_adr_ex = '0;
  logic             wbk_rd_reg_ex = 1'b0;
  logic             rst_pipe, stall, stall_1shot, stall_dly;
  logic             stall_ld, stall_ld_ex, stall_ld_ma;
  logic [CNT_W-1:0] perf_stall_cnt, perf_ld_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stall_ctrl #(.RST_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_start(cpu_start), .stall_req(stall_req),
    .jmp_purge_ex(jmp_purge_ex), .inst_rs1_id(inst_rs1_id), .inst_rs2_id(inst_rs2_id),
    .inst_rs1_valid(inst_rs1_valid), .inst_rs2_valid(inst_rs2_valid),
    .cmd_ld_ex(cmd_ld_ex), .rd_adr_ex(rd_adr_ex), .wbk_rd_reg_ex(wbk_rd_reg_ex),
    .rst_pipe(rst_pipe), .stall(stall), .stall_1shot(stall_1shot), .stall_dly(stall_dly),
    .stall_ld(stall_ld), .stall_ld_ex(stall_ld_ex), .stall_ld_ma(stall_ld_ma),
    .perf_stall_cnt(perf_stall_cnt), .perf_ld_cnt(perf_ld_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag, input int s, input int l);
`ifdef STALL_CTRL_PERF_EN
    chk({tag, "_stall_cnt"}, 32'(perf_stall_cnt), s);
    chk({tag, "_ld_cnt"}, 32'(perf_ld_cnt), l);
`else
    chk({tag, "_stall_cnt"}, 32'(perf_stall_cnt), 0);
    chk({tag, "_ld_cnt"}, 32'(perf_ld_cnt), 0);
`endif
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic haz(input logic ld, input logic wb, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic v1,
                     input logic [4:0] rs2, input logic v2);
    cmd_ld_ex = ld; wbk_rd_reg_ex = wb; rd_adr_ex = rd;
    inst_rs1_id = rs1; inst_rs1_valid = v1;
    inst_rs2_id = rs2; inst_rs2_valid = v2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rst_pipe", 32'(rst_pipe), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_stall_dly", 32'(stall_dly), 0);
    chk("rst_ld_ex", 32'(stall_ld_ex), 0);
    chk("rst_ld_ma", 32'(stall_ld_ma), 0);
    chk_perf("rst", 0, 0);

    // Flush after reset release: 4 cycles of rst_pipe.
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("flush_rst_pipe_%0d", i), 32'(rst_pipe), 1);
      chk($sformatf("flush_stall_%0d", i), 32'(stall), 0);
      tick;
    end
    chk("flush_done", 32'(rst_pipe), 0);

    // lw x5 in EX, add x6,x5,x1 in ID.
    haz(1, 1, 5'd5, 5'd5, 1, 5'd1, 1);
    #1 chk("lu_stall_ld", 32'(stall_ld), 1);
    tick;
    chk("lu_ld_ex", 32'(stall_ld_ex), 1);
    chk("lu_ld_ma0", 32'(stall_ld_ma), 0);
    chk("lu_one_bubble", 32'(stall_ld), 0);
    haz(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("lu_ld_ex_off", 32'(stall_ld_ex), 0);
    chk("lu_ld_ma", 32'(stall_ld_ma), 1);
    tick;
    chk("lu_ld_ma_off", 32'(stall_ld_ma), 0);

    // Combinational-only hazard checks (cleared before the next edge).
    haz(1, 1, 5'd0, 5'd0, 1, 5'd0, 1);
    #1 chk("lu_rd_x0", 32'(stall_ld), 0);
    haz(1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    jmp_purge_ex = 1'b1;
    #1 chk("lu_jmp_purge", 32'(stall_ld), 0);
    jmp_purge_ex = 1'b0;
    #1 chk("lu_no_purge", 32'(stall_ld), 1);
    haz(0, 0, 0, 0, 0, 0, 0);
    tick;
    haz(1, 1, 5'd7, 5'd3, 1, 5'd7, 1);
    #1 chk("lu_rs2_match", 32'(stall_ld), 1);
    haz(1, 1, 5'd7, 5'd3, 1, 5'd7, 0);
    #1 chk("lu_rs2_invalid", 32'(stall_ld), 0);
    haz(1, 0, 5'd7, 5'd7, 1, 5'd0, 0);
    #1 chk("lu_no_wbk", 32'(stall_ld), 0);
    haz(0, 0, 0, 0, 0, 0, 0);

    // stall_req high for 3 cycles starting at cycle 10.
    tick;
    stall_req = 1'b1;
    chk("sr_c10_stall", 32'(stall), 0);
    tick;
    chk("sr_c11_stall", 32'(stall), 1);
    chk("sr_c11_1shot", 32'(stall_1shot), 1);
    chk("sr_c11_dly", 32'(stall_dly), 0);
    tick;
    chk("sr_c12_stall", 32'(stall), 1);
    chk("sr_c12_1shot", 32'(stall_1shot), 0);
    chk("sr_c12_dly", 32'(stall_dly), 1);
    tick;
    stall_req = 1'b0;
    chk("sr_c13_stall", 32'(stall), 1);
    chk("sr_c13_dly", 32'(stall_dly), 1);
    tick;
    chk("sr_c14_stall", 32'(stall), 0);
    chk("sr_c14_dly", 32'(stall_dly), 1);
    chk("sr_c14_1shot", 32'(stall_1shot), 0);
    tick;
    chk("sr_c15_dly", 32'(stall_dly), 0);
    chk_perf("perf_a", 3, 1);

    // stall_req together with a load-use hazard.
    haz(1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    stall_req = 1'b1;
    #1 chk("sim_stall_ld", 32'(stall_ld), 1);
    tick;
    chk("sim_stall", 32'(stall), 1);
    chk("sim_ld_ex", 32'(stall_ld_ex), 1);
    chk("sim_ld_gated", 32'(stall_ld), 0);
    tick;
    chk("sim_ld_ex_frozen", 32'(stall_ld_ex), 1);
    chk("sim_ld_ma_frozen", 32'(stall_ld_ma), 0);
    stall_req = 1'b0;
    tick;
    chk("sim_released", 32'(stall), 0);
    chk("sim_ld_ex_hold", 32'(stall_ld_ex), 1);
    chk("sim_no_second", 32'(stall_ld), 0);
    haz(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("sim_ld_ma", 32'(stall_ld_ma), 1);
    chk_perf("perf_b", 5, 2);

    // Hazard issued with cpu_start: flush clears the bubble shift.
    haz(1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    cpu_start = 1'b1;
    #1 chk("cs_stall_ld", 32'(stall_ld), 1);
    tick;
    haz(0, 0, 0, 0, 0, 0, 0);
    cpu_start = 1'b0;
    chk("cs_rst_pipe", 32'(rst_pipe), 1);
    chk("cs_ld_ex", 32'(stall_ld_ex), 1);
    tick;
    chk("cs_ld_ex_clr", 32'(stall_ld_ex), 0);
    chk("cs_ld_ma_clr", 32'(stall_ld_ma), 0);
    tick; chk("cs_f2", 32'(rst_pipe), 1);
    tick; chk("cs_f3", 32'(rst_pipe), 1);
    tick; chk("cs_f4_run", 32'(rst_pipe), 0);

    // cpu_start during the flush extends it.
    cpu_start = 1'b1;
    tick;
    cpu_start = 1'b0;
    chk("ext_g0", 32'(rst_pipe), 1);
    tick;
    cpu_start = 1'b1;
    tick;
    cpu_start = 1'b0;
    tick; tick; tick;
    chk("ext_g5", 32'(rst_pipe), 1);
    tick;
    chk("ext_g6_run", 32'(rst_pipe), 0);

    // cpu_start while stalled with stall_req held.
    stall_req = 1'b1;
    tick;
    chk("css_stall", 32'(stall), 1);
    cpu_start = 1'b1;
    tick;
    cpu_start = 1'b0;
    chk("css_rst_pipe", 32'(rst_pipe), 1);
    chk("css_stall_off", 32'(stall), 0);
    for (int i = 1; i < 4; i++) begin
      tick;
      chk($sformatf("css_h%0d_rst", i), 32'(rst_pipe), 1);
      chk($sformatf("css_h%0d_stall", i), 32'(stall), 0);
    end
    tick;
    chk("css_h4_rst", 32'(rst_pipe), 0);
    chk("css_h4_stall", 32'(stall), 0);
    tick;
    chk("css_h5_stall", 32'(stall), 1);
    chk("css_h5_1shot", 32'(stall_1shot), 1);

    // Hold the stall long enough to saturate the 4-bit counter.
    for (int i = 0; i < 16; i++) tick;
    chk_perf("sat_a", 15, 3);
    tick; tick;
    chk_perf("sat_b", 15, 3);

    // Asynchronous reset mid-stall.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rst_pipe", 32'(rst_pipe), 1);
    chk("arst_stall", 32'(stall), 0);
    chk("arst_dly", 32'(stall_dly), 0);
    chk_perf("arst", 0, 0);
    stall_req = 1'b0;
    tick;
    rst_n = 1'b1;
    tick; tick; tick;
    chk("arst_flush3", 32'(rst_pipe), 1);
    tick;
    chk("arst_flush_done", 32'(rst_pipe), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
